// File: rtl/sd_serializer.sv
// Signed-digit serializer: recodes an N-bit two's-complement operand and emits digits MSB-first, one per cycle.
// Optional NAF_RECODE_EN adds an N-cycle NAF recode pass; without it the operand bits are mapped directly.
module sd_serializer #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] operand,
  input  logic         hold,
  output logic         busy,
  output logic         valid,
  output logic [1:0]   digit,
  output logic         last,
  output logic         done
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RECODE, EMIT, DONE} state_t;

  state_t              state;
  logic [N-1:0][1:0]   dbuf;
  logic [PW-1:0]       p;
  logic                fin;

`ifdef NAF_RECODE_EN
  localparam logic signed [N:0] ONE = (N+1)'(1);

  logic signed [N:0]   x;
  logic signed [N:0]   x_next;
  logic [PW-1:0]       k;
  logic [1:0]          rd;

  // One NAF step: pick the digit that leaves x even, then halve.
  always_comb begin
    rd     = 2'b00;
    x_next = x >>> 1;
    case (x[1:0])
      2'b01: begin
        rd     = 2'b01;
        x_next = (x - ONE) >>> 1;
      end
      2'b11: begin
        rd     = 2'b10;
        x_next = (x + ONE) >>> 1;
      end
      default: ;
    endcase
  end
`else
  logic [N-1:0][1:0]   plain_buf;

  // The sign bit carries weight -2^(N-1); all other set bits are +1.
  always_comb begin
    plain_buf = '0;
    for (int i = 0; i < N; i++) begin
      if (operand[i])
        plain_buf[i] = (i == N-1) ? 2'b10 : 2'b01;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      valid <= 1'b0;
      digit <= 2'b00;
      last  <= 1'b0;
      done  <= 1'b0;
      dbuf  <= '0;
      p     <= '0;
      fin   <= 1'b0;
`ifdef NAF_RECODE_EN
      x     <= '0;
      k     <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          valid <= 1'b0;
          last  <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            fin  <= 1'b0;
            p    <= PW'(N-1);
`ifdef NAF_RECODE_EN
            x     <= {operand[N-1], operand};
            k     <= '0;
            state <= RECODE;
`else
            dbuf  <= plain_buf;
            state <= EMIT;
`endif
          end
        end
`ifdef NAF_RECODE_EN
        RECODE: begin
          dbuf[k] <= rd;
          x       <= x_next;
          if (k == PW'(N-1))
            state <= EMIT;
          else
            k <= k + 1'b1;
        end
`endif
        EMIT: begin
          // fin marks that the weight-2^0 digit has gone out; the next edge closes the frame.
          if (fin) begin
            valid <= 1'b0;
            last  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (hold) begin
            valid <= 1'b0;
            last  <= 1'b0;
          end else begin
            valid <= 1'b1;
            digit <= dbuf[p];
            last  <= (p == '0);
            if (p == '0)
              fin <= 1'b1;
            else
              p <= p - 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_serializer.sv
// Directed bench for sd_serializer: table of operands with hand-derived digit streams for both builds.
module tb_sd_serializer;

  localparam int N = 16;
`ifdef NAF_RECODE_EN
  localparam bit NAF = 1'b1;
  localparam int LAT = N;
`else
  localparam bit NAF = 1'b0;
  localparam int LAT = 0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         hold = 1'b0;
  logic [N-1:0] operand = '0;
  logic         busy, valid, last, done;
  logic [1:0]   digit;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sd_serializer #(.N(N)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .operand (operand),
    .hold    (hold),
    .busy    (busy),
    .valid   (valid),
    .digit   (digit),
    .last    (last),
    .done    (done)
  );

  // Digit streams are packed MSB-first: bits [2k+1:2k] hold the digit of weight 2^k.
  typedef struct {
    logic [15:0] op;
    logic [31:0] exp_naf;
    logic [31:0] exp_pln;
    int          hold_at;
    int          hold_len;
    bit          poke;
  } vec_t;

  vec_t vt[7];
  vec_t v_one;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input vec_t v);
    logic [31:0] exp_d, got;
    int nd, held, first_c, last_c, done_c, n_last;
    bit hb, last_ok;
    exp_d   = NAF ? v.exp_naf : v.exp_pln;
    got     = '0;
    nd      = 0;
    held    = 0;
    first_c = -1;
    last_c  = -1;
    done_c  = -1;
    n_last  = 0;
    last_ok = 1'b0;
    operand = v.op;
    start   = 1'b1;
    step();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    for (int cyc = 1; cyc <= 150 && done_c < 0; cyc++) begin
      hb   = (nd == v.hold_at) && (held < v.hold_len);
      hold = hb;
      step();
      if (hb) held++;
      if (valid) begin
        got = {got[29:0], digit};
        nd++;
        if (nd == 1) first_c = cyc;
      end
      if (last) begin
        n_last++;
        last_c  = cyc;
        last_ok = valid && (nd == N);
      end
      if (done) done_c = cyc;
    end
    hold = 1'b0;
    chk("digits", got, exp_d);
    chk("digit_count", nd, N);
    chk("first_valid_cycle", first_c, LAT + 1);
    chk("last_cycle", last_c, LAT + N + v.hold_len);
    chk("last_once", n_last, 1);
    chk("last_with_final_digit", last_ok, 1);
    chk("done_cycle", done_c, LAT + N + v.hold_len + 1);
    chk("busy_in_done_cycle", busy, 1);
    if (v.poke) begin
      start   = 1'b1;
      operand = 16'h1234;
    end
    step();
    start = 1'b0;
    chk("busy_after_done", busy, 0);
    chk("done_single_cycle", done, 0);
    if (v.poke) begin
      step();
      chk("poke_ignored_busy", busy, 0);
      chk("poke_ignored_valid", valid, 0);
    end
  endtask

  initial begin
    int nd, n_bad;

    vt[0] = '{16'h0007, 32'h0000_0042, 32'h0000_0015, -1, 0, 1'b0};
    vt[1] = '{16'h7FFF, 32'h4000_0002, 32'h1555_5555, -1, 0, 1'b0};
    vt[2] = '{16'h8000, 32'h8000_0000, 32'h8000_0000, -1, 0, 1'b0};
    vt[3] = '{16'hFFFF, 32'h0000_0002, 32'h9555_5555, -1, 0, 1'b0};
    vt[4] = '{16'h5555, 32'h1111_1111, 32'h1111_1111, -1, 0, 1'b1};
    vt[5] = '{16'h00FF, 32'h0001_0002, 32'h0000_5555,  5, 3, 1'b0};
    vt[6] = '{16'hFF00, 32'h0002_0000, 32'h9555_0000, 15, 2, 1'b0};
    v_one = '{16'h0001, 32'h0000_0001, 32'h0000_0001, -1, 0, 1'b0};

    // Reset held low with start asserted must keep everything quiet.
    reset   = 1'b0;
    start   = 1'b1;
    operand = 16'h0007;
    step();
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_digit", digit, 0);
    chk("rst_last", last, 0);
    chk("rst_done", done, 0);
    start = 1'b0;
    reset = 1'b1;
    step();
    chk("idle_after_release", busy, 0);

    for (int i = 0; i < 7; i++)
      run_frame(vt[i]);

    // Abort a frame after its 8th digit.
    operand = 16'h00FF;
    start   = 1'b1;
    step();
    start = 1'b0;
    nd = 0;
    for (int c = 0; c < 100 && nd < 8; c++) begin
      step();
      if (valid) nd++;
    end
    chk("abort_reached_digit8", nd, 8);
    #2 reset = 1'b0;
    #1;
    chk("abort_valid_drop", valid, 0);
    chk("abort_busy_drop", busy, 0);
    chk("abort_digit_clear", digit, 0);
    n_bad = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (last || done || valid || busy) n_bad++;
    end
    chk("abort_quiet", n_bad, 0);
    reset = 1'b1;
    step();
    chk("abort_idle", busy, 0);
    run_frame(v_one);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_serializer.md
# sd_serializer

Transmit-side companion of the on-the-fly signed-digit converter. It accepts an N-bit two's-complement operand and recodes it into radix-2 signed digits {-1, 0, +1}. It then emits the digits MSB-first, one per cycle, on a valid/digit stream with the same encoding the converter consumes. It sits upstream of the converter in digit-serial datapaths and in loopback benches.

## Interface
- N, 16: digits per frame, equal to the operand width; N ≥ 4.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; low forces all state and outputs to reset values immediately.
- start  in  1  request to load `operand`; honoured only in IDLE.
- operand  in  N  two's-complement value, sampled on the edge that accepts `start`.
- hold  in  1  stalls emission while high; ignored outside EMIT.
- busy  out  1  high in every state except IDLE.
- valid  out  1  `digit` is meaningful this cycle.
- digit  out  2  signed digit: 2'b01 = +1, 2'b10 = -1, 2'b00 = 0; 2'b11 is never driven.
- last  out  1  high with the valid digit of weight 2^0.
- done  out  1  one-cycle pulse after the frame completes.

## Operation
- States and transitions:
  - IDLE → RECODE on `start`.
  - RECODE → EMIT after N steps.
  - EMIT → DONE after N digits.
  - DONE → IDLE unconditionally.
- RECODE (NAF, LSB-first):
  - Working register x is N+1 bits, holding `operand` sign-extended.
  - Each edge computes digit k, with k counting 0..N-1:
    - x[1:0]=01 gives +1.
    - x[1:0]=11 gives -1.
    - Even x gives 0.
  - After each digit: x ← (x − d) >>> 1, arithmetic shift.
  - Digit k is stored in buffer slot k. After N steps x is 0 for every legal operand.
- EMIT:
  - Pointer p runs N-1 down to 0.
  - Each edge with hold=0 registers valid=1, digit=buf[p], last=(p==0), then decrements p.
  - Each edge with hold=1 registers valid=0 and last=0; `digit` keeps its last value and p is unchanged.
- DONE: valid=0, last=0, done=1 for exactly one cycle.
- Frame invariant: Σ digit_k·2^k equals `operand` as a signed value.
- Boundary rules:
  - `start` while busy, including the DONE cycle, is ignored; `operand` is not re-sampled.
  - Back-to-back frames are legal: `start` in the cycle after `done` is accepted.
  - Reset asserted mid-RECODE or mid-EMIT aborts the frame. No `last` or `done` is produced, and the block returns to IDLE.
  - `hold` asserted on the final digit delays both `last` and `done`.

## Timing
- Reset values: busy=0, valid=0, digit=2'b00, last=0, done=0, state IDLE.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Let `start` be accepted at edge E0, with NAF_RECODE_EN defined and hold=0 throughout:
  - busy=1 after E0.
  - First valid digit (weight 2^(N-1)) appears after E(N+1).
  - Last digit appears after E(2N).
  - done appears after E(2N+1).
  - busy=0 after E(2N+2).
- Each hold=1 cycle in EMIT adds exactly one cycle to every subsequent event.
- Digits are contiguous when hold=0: N consecutive valid cycles.

## Configuration
- NAF_RECODE_EN defined:
  - NAF recoding as above; no two adjacent non-zero digits.
- NAF_RECODE_EN undefined:
  - RECODE is removed, and IDLE goes directly to EMIT.
  - The first digit appears after E1 and done after E(N+1).
  - Digit mapping: bit N-1 set gives -1, bit k<N-1 set gives +1, clear bit gives 0.
- The interface and EMIT/DONE behaviour are identical in both builds.

## Test plan
- Reset: hold reset low with start=1 → all outputs 0, busy=0. Release → IDLE; an accepted start then runs normally.
- operand 16'h0007, NAF build → digits MSB-first: 12×00, 01, 00, 00, 10.
  - Timing: first valid after E17, last with the 16th digit, done after E33.
  - Plain build: 13×00, 01, 01, 01.
- operand 16'h7FFF → 01, 14×00, 10 (NAF build).
  - operand 16'h8000 → 10, 15×00 in both builds.
  - operand 16'hFFFF → NAF 15×00, 10; plain 10, 15×01.
- operand 16'h5555 → alternating 00, 01 starting with 00; the NAF and plain builds match.
  - Pulse start again in the DONE cycle with operand 16'h1234 → ignored.
- hold=1 for 3 cycles after the 5th digit → valid low for exactly 3 cycles, no digit lost or duplicated, done delayed by 3.
  - hold=1 on the final digit → last and done deferred.
- Reset low mid-EMIT after digit 8 → valid drops immediately, no last, no done.
  - A new start with 16'h0001 → frame 15×00, 01 correct.
